// File: rtl/uart_rx_frame.sv
// ---------------------------------------------------------------------------
// uart_rx_frame
// Front-end UART receiver. Deserialises asynchronous 8N1 frames arriving on
// uart_rx into bytes and presents them on a valid/ready port. Framing errors
// and overruns are reported as single-cycle pulses.
//
// Optional feature macro: UART_RX_PARITY_EN
//   undefined (default) : 8N1 frame, no parity state, no rx_parity_err port.
//   defined             : 8E1 frame, a PARITY state sits between DATA and
//                         STOP and rx_parity_err pulses on a parity mismatch.
//
// Line conditioning: 2-FF synchroniser followed by a 3-deep history; every
// bit sample is the majority vote of that history, which rejects single
// cycle spikes near the sample point.
// ---------------------------------------------------------------------------
module uart_rx_frame #(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int BAUD_RATE = 115200
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       uart_rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       rx_frame_err,
`ifdef UART_RX_PARITY_EN
  output logic       rx_parity_err,
`endif
  output logic       rx_overrun
);

  // -------------------------------------------------------------------------
  // Bit timing
  // -------------------------------------------------------------------------
  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT + 1);

  // Terminal counts: the counter starts at 0, so a span of N clocks ends at N-1.
  localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  // -------------------------------------------------------------------------
  // Receiver states
  // -------------------------------------------------------------------------
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
    ST_PARITY = 3'd3,
`endif
    ST_STOP   = 3'd4
  } rx_state_t;

  // -------------------------------------------------------------------------
  // Helper functions
  // -------------------------------------------------------------------------

  // Majority of three history bits: the value seen in at least two of them.
  function automatic logic maj3(input logic [2:0] h);
    return (h[0] & h[1]) | (h[0] & h[2]) | (h[1] & h[2]);
  endfunction

`ifdef UART_RX_PARITY_EN
  // Even parity holds when data bits plus parity bit carry an even number of ones.
  function automatic logic even_parity_ok(input logic [7:0] d, input logic p);
    return ~(^{d, p});
  endfunction
`endif

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  logic             r_sync1;
  logic             r_sync2;
  logic [2:0]       r_hist;
  rx_state_t        r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_bit_cnt;
  logic [7:0]       r_shift;
  logic [7:0]       r_data;
  logic             r_valid;
  logic             r_frame_err;
  logic             r_overrun;
`ifdef UART_RX_PARITY_EN
  logic             r_par;
  logic             r_parity_err;
`endif

  // -------------------------------------------------------------------------
  // Combinational decode
  // -------------------------------------------------------------------------
  logic w_sample;
  logic w_fall;
  logic w_half_tick;
  logic w_full_tick;
  logic w_stop_done;
  logic w_byte_ok;

  assign w_sample    = maj3(r_hist);
  // Falling edge of the synchronised line: previous synced value high, current low.
  assign w_fall      = r_hist[0] & ~r_sync2;
  assign w_half_tick = (r_cnt == HALF_LAST);
  assign w_full_tick = (r_cnt == FULL_LAST);
  assign w_stop_done = (r_state == ST_STOP) && w_full_tick;

`ifdef UART_RX_PARITY_EN
  assign w_byte_ok = w_stop_done && w_sample && even_parity_ok(r_shift, r_par);
`else
  assign w_byte_ok = w_stop_done && w_sample;
`endif

  // -------------------------------------------------------------------------
  // Sequential logic
  // -------------------------------------------------------------------------

  // Synchronise the asynchronous line and keep a 3-sample history for voting.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_hist  <= 3'b111;
    end else begin
      r_sync1 <= uart_rx;
      r_sync2 <= r_sync1;
      r_hist  <= {r_hist[1:0], r_sync2};
    end
  end

  // Frame FSM plus output register, handshake and error pulses.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state      <= ST_IDLE;
      r_cnt        <= CNT_ZERO;
      r_bit_cnt    <= 3'd0;
      r_shift      <= 8'h00;
      r_data       <= 8'h00;
      r_valid      <= 1'b0;
      r_frame_err  <= 1'b0;
      r_overrun    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_par        <= 1'b0;
      r_parity_err <= 1'b0;
`endif
    end else begin
      // Error outputs are single-cycle pulses; they default low every cycle.
      r_frame_err  <= 1'b0;
      r_overrun    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_parity_err <= 1'b0;
`endif

      case (r_state)
        ST_IDLE: begin
          r_cnt     <= CNT_ZERO;
          r_bit_cnt <= 3'd0;
          if (w_fall) begin
            r_state <= ST_START;
          end else begin
            r_state <= ST_IDLE;
          end
        end

        ST_START: begin
          // Check the start bit at its centre; a high vote means a glitch.
          if (w_half_tick) begin
            r_cnt <= CNT_ZERO;
            if (w_sample) begin
              r_state <= ST_IDLE;
            end else begin
              r_state <= ST_DATA;
            end
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end

        ST_DATA: begin
          // One full bit period after a centre lands on the next centre.
          if (w_full_tick) begin
            r_cnt   <= CNT_ZERO;
            r_shift <= {w_sample, r_shift[7:1]};
            if (r_bit_cnt == 3'd7) begin
              r_bit_cnt <= 3'd0;
`ifdef UART_RX_PARITY_EN
              r_state   <= ST_PARITY;
`else
              r_state   <= ST_STOP;
`endif
            end else begin
              r_bit_cnt <= r_bit_cnt + 3'd1;
            end
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end

`ifdef UART_RX_PARITY_EN
        ST_PARITY: begin
          if (w_full_tick) begin
            r_cnt   <= CNT_ZERO;
            r_par   <= w_sample;
            r_state <= ST_STOP;
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end
`endif

        ST_STOP: begin
          // Return to IDLE at the stop centre so a back-to-back start edge
          // half a bit later is still caught.
          if (w_full_tick) begin
            r_cnt   <= CNT_ZERO;
            r_state <= ST_IDLE;
            if (!w_sample) begin
              r_frame_err <= 1'b1;
`ifdef UART_RX_PARITY_EN
            end else if (!even_parity_ok(r_shift, r_par)) begin
              r_parity_err <= 1'b1;
`endif
            end else begin
              r_frame_err <= 1'b0;
            end
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end

        default: begin
          r_state   <= ST_IDLE;
          r_cnt     <= CNT_ZERO;
          r_bit_cnt <= 3'd0;
        end
      endcase

      // Output register: a finished byte loads if the slot is empty or is
      // being emptied this very cycle; otherwise it is dropped as an overrun.
      if (w_byte_ok) begin
        if (!r_valid || rx_ready) begin
          r_data  <= r_shift;
          r_valid <= 1'b1;
        end else begin
          r_overrun <= 1'b1;
        end
      end else if (r_valid && rx_ready) begin
        r_valid <= 1'b0;
      end else begin
        r_valid <= r_valid;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Outputs come straight from registers
  // -------------------------------------------------------------------------
  assign rx_data       = r_data;
  assign rx_valid      = r_valid;
  assign rx_frame_err  = r_frame_err;
  assign rx_overrun    = r_overrun;
`ifdef UART_RX_PARITY_EN
  assign rx_parity_err = r_parity_err;
`endif

endmodule

// File: tb/tb_uart_rx_frame.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_frame
// Directed bench for uart_rx_frame at default parameters: 20 ns clock,
// 8680 ns bit period. A monitor accumulates handshake/error event counts on
// the falling clock edge; each test snapshots the counts and compares the
// deltas against hand-computed expectations.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_uart_rx_frame;

  localparam int CLK_HALF_NS = 10;
  localparam int BIT_NS      = 8680;

  logic       sys_clk;
  logic       sys_rst_n;
  logic       uart_rx;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       rx_frame_err;
  logic       rx_overrun;
`ifdef UART_RX_PARITY_EN
  logic       rx_parity_err;
`endif

  uart_rx_frame dut (
    .sys_clk      (sys_clk),
    .sys_rst_n    (sys_rst_n),
    .uart_rx      (uart_rx),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready),
    .rx_frame_err (rx_frame_err),
`ifdef UART_RX_PARITY_EN
    .rx_parity_err(rx_parity_err),
`endif
    .rx_overrun   (rx_overrun)
  );

  initial sys_clk = 1'b0;
  always #(CLK_HALF_NS) sys_clk = ~sys_clk;

  // ------------------------------------------------------------ monitor
  int         n_xfer;
  int         n_vcyc;
  int         n_ferr;
  int         n_ovr;
  int         n_perr;
  int         n_unstable;
  logic [7:0] last_data;
  logic       prev_hold;
  logic [7:0] prev_data;

  initial begin
    n_xfer = 0; n_vcyc = 0; n_ferr = 0; n_ovr = 0; n_perr = 0;
    n_unstable = 0; last_data = 8'h00; prev_hold = 1'b0; prev_data = 8'h00;
  end

  // Accumulate transfer/error events and flag any data change while held.
  always @(negedge sys_clk) begin
    if (rx_valid && rx_ready) begin
      n_xfer    <= n_xfer + 1;
      last_data <= rx_data;
    end
    if (rx_valid)     n_vcyc <= n_vcyc + 1;
    if (rx_frame_err) n_ferr <= n_ferr + 1;
    if (rx_overrun)   n_ovr  <= n_ovr + 1;
`ifdef UART_RX_PARITY_EN
    if (rx_parity_err) n_perr <= n_perr + 1;
`endif
    if (prev_hold && rx_valid && (rx_data != prev_data)) n_unstable <= n_unstable + 1;
    prev_hold <= rx_valid && !rx_ready;
    prev_data <= rx_data;
  end

  // ------------------------------------------------------------ checking
  int n_tests;
  int n_fail;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ------------------------------------------------------------ stimulus
  int s_xfer, s_vcyc, s_ferr, s_ovr, s_perr;

  task automatic snap();
    s_xfer = n_xfer; s_vcyc = n_vcyc; s_ferr = n_ferr; s_ovr = n_ovr; s_perr = n_perr;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_bit, input logic par_flip);
    uart_rx = 1'b0;
    #(BIT_NS);
    for (int i = 0; i < 8; i++) begin
      uart_rx = d[i];
      #(BIT_NS);
    end
`ifdef UART_RX_PARITY_EN
    uart_rx = (^d) ^ par_flip;
    #(BIT_NS);
`endif
    uart_rx = stop_bit;
    #(BIT_NS);
    uart_rx = 1'b1;
  endtask

  task automatic settle();
    #(BIT_NS);
    @(negedge sys_clk);
    #1;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    uart_rx   = 1'b1;
    rx_ready  = 1'b1;
    sys_rst_n = 1'b0;

    // Reset state
    #100;
    sys_rst_n = 1'b1;
    repeat (5) @(negedge sys_clk);
    #1;
    check_eq("reset_valid", {31'd0, rx_valid}, 32'd0);
    check_eq("reset_data", {24'd0, rx_data}, 32'h00);
    check_eq("reset_ferr", {31'd0, rx_frame_err}, 32'd0);
    check_eq("reset_ovr", {31'd0, rx_overrun}, 32'd0);
`ifdef UART_RX_PARITY_EN
    check_eq("reset_perr", {31'd0, rx_parity_err}, 32'd0);
`endif

    // Single byte 0x41 with consumer ready
    snap();
    send_frame(8'h41, 1'b1, 1'b0);
    settle();
    check_eq("a41_xfer", n_xfer - s_xfer, 32'd1);
    check_eq("a41_vcyc", n_vcyc - s_vcyc, 32'd1);
    check_eq("a41_data", {24'd0, last_data}, 32'h41);
    check_eq("a41_ferr", n_ferr - s_ferr, 32'd0);
    check_eq("a41_ovr", n_ovr - s_ovr, 32'd0);

    // 2 us glitch must be rejected, then 0x55 delivered
    snap();
    uart_rx = 1'b0;
    #2000;
    uart_rx = 1'b1;
    settle();
    check_eq("glitch_xfer", n_xfer - s_xfer, 32'd0);
    check_eq("glitch_ferr", n_ferr - s_ferr, 32'd0);
    check_eq("glitch_perr", n_perr - s_perr, 32'd0);
    snap();
    send_frame(8'h55, 1'b1, 1'b0);
    settle();
    check_eq("a55_xfer", n_xfer - s_xfer, 32'd1);
    check_eq("a55_data", {24'd0, last_data}, 32'h55);

    // Stop bit forced low
    snap();
    send_frame(8'hA5, 1'b0, 1'b0);
    settle();
    check_eq("ferr_pulses", n_ferr - s_ferr, 32'd1);
    check_eq("ferr_vcyc", n_vcyc - s_vcyc, 32'd0);
    check_eq("ferr_perr", n_perr - s_perr, 32'd0);
`ifdef UART_RX_PARITY_EN
    snap();
    send_frame(8'h03, 1'b1, 1'b1);
    settle();
    check_eq("perr_pulses", n_perr - s_perr, 32'd1);
    check_eq("perr_vcyc", n_vcyc - s_vcyc, 32'd0);
    check_eq("perr_ferr", n_ferr - s_ferr, 32'd0);
`endif

    // Overrun: consumer stalled across two frames
    @(posedge sys_clk);
    #1;
    rx_ready = 1'b0;
    snap();
    send_frame(8'h12, 1'b1, 1'b0);
    send_frame(8'h34, 1'b1, 1'b0);
    settle();
    check_eq("ovr_pulses", n_ovr - s_ovr, 32'd1);
    check_eq("ovr_hold_valid", {31'd0, rx_valid}, 32'd1);
    check_eq("ovr_hold_data", {24'd0, rx_data}, 32'h12);
    check_eq("ovr_no_xfer", n_xfer - s_xfer, 32'd0);
    @(posedge sys_clk);
    #1;
    rx_ready = 1'b1;
    repeat (3) @(negedge sys_clk);
    #1;
    check_eq("ovr_xfer", n_xfer - s_xfer, 32'd1);
    check_eq("ovr_xfer_data", {24'd0, last_data}, 32'h12);
    check_eq("ovr_valid_low", {31'd0, rx_valid}, 32'd0);

    // Reset mid-frame after bit 3 of 0x7E, then a clean 0x7E
    snap();
    begin
      logic [7:0] d7e;
      d7e = 8'h7E;
      uart_rx = 1'b0;
      #(BIT_NS);
      for (int i = 0; i < 4; i++) begin
        uart_rx = d7e[i];
        #(BIT_NS);
      end
    end
    sys_rst_n = 1'b0;
    uart_rx   = 1'b1;
    #100;
    sys_rst_n = 1'b1;
    #(4 * BIT_NS);
    check_eq("abort_xfer", n_xfer - s_xfer, 32'd0);
    check_eq("abort_ferr", n_ferr - s_ferr, 32'd0);
    check_eq("abort_valid", {31'd0, rx_valid}, 32'd0);
    snap();
    send_frame(8'h7E, 1'b1, 1'b0);
    settle();
    check_eq("a7e_xfer", n_xfer - s_xfer, 32'd1);
    check_eq("a7e_data", {24'd0, last_data}, 32'h7E);
    check_eq("a7e_ferr", n_ferr - s_ferr, 32'd0);
    check_eq("a7e_ovr", n_ovr - s_ovr, 32'd0);

    check_eq("data_stable", n_unstable, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
